// File: rtl/cache_mem_arb_pkg.sv
// Shared types for the L1-cache / RAM arbiter: RAM handshake states,
// arbiter FSM states and the default starvation limit.
package cache_mem_arb_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBUS = 2'd1,
    IBUS = 2'd2
  } arb_state_t;

  localparam int STARVE_MAX_DEF = 8;
  localparam int ARB_STARVE_W   = $clog2(STARVE_MAX_DEF + 1);

endpackage

// File: rtl/cache_mem_arb.sv
// Single-port RAM arbiter between icache and dcache. dcache has priority;
// a saturating starvation counter forces the icache in at a word boundary.
module cache_mem_arb
  import cache_mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      busErr
);

  localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;

  logic             dreq_s;
  logic             ram_access_s;
  logic [CNT_W-1:0] beat_cnt_s;

  assign dreq_s       = dREN | dWEN;
  assign ram_access_s = (ramstate == ACCESS);
  assign busErr       = bus_err_q;
  assign iload        = ramload;
  assign dload        = ramload;

  // Starvation count a dcache ACCESS beat would produce this cycle.
  always_comb begin
    beat_cnt_s = '0;
    if (iREN) begin
      if (cnt_q == CNT_MAX) begin
        beat_cnt_s = CNT_MAX;
      end else begin
        beat_cnt_s = cnt_q + CNT_ONE;
      end
    end else begin
      beat_cnt_s = '0;
    end
  end

  // Arbitration next-state, starvation counter and sticky error update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q | ((state_q != IDLE) && (ramstate == ERROR));
    case (state_q)
      IDLE: begin
        if (dreq_s && !(iREN && (cnt_q == CNT_MAX))) begin
          state_d = DBUS;
        end else if (iREN) begin
          state_d = IBUS;
        end else begin
          state_d = IDLE;
        end
      end
      DBUS: begin
        // Preemption is only taken on a completed beat, never mid-word.
        if (ram_access_s) begin
          cnt_d = beat_cnt_s;
          if (iREN && (beat_cnt_s == CNT_MAX)) begin
            state_d = IBUS;
          end else if (!dreq_s) begin
            state_d = IDLE;
          end else begin
            state_d = DBUS;
          end
        end else if (!dreq_s) begin
          state_d = IDLE;
        end else begin
          state_d = DBUS;
        end
      end
      IBUS: begin
        if (ram_access_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!iREN) begin
          state_d = IDLE;
        end else begin
          state_d = IBUS;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // RAM port mux and wait generation from the registered grant.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      DBUS: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~ram_access_s;
      end
      IBUS: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        iwait   = ~ram_access_s;
      end
      default: begin
        ramREN = 1'b0;
        ramWEN = 1'b0;
      end
    endcase
  end

endmodule
